// File: rtl/nn_seq_pkg.sv
// Shared definitions for the LA command sequencer: opcodes, error codes and FSM states.
package nn_seq_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_READ    = 3'd2;
  localparam logic [2:0] OP_FORWARD = 3'd3;
  localparam logic [2:0] OP_TRAIN   = 3'd4;
  localparam logic [2:0] OP_CLR_ERR = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BOTH    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_CAP,
    S_FWD,
    S_FWD_WAIT,
    S_BWD,
    S_BWD_WAIT,
    S_FIN
  } seq_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_CLR_ERR);
  endfunction

endpackage

// File: rtl/nn_toggle_sync.sv
// Two-flop synchronizer with asynchronous reset, for single-bit LA strobes.
module nn_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/nn_la_sequencer.sv
// Command sequencer between firmware-driven LA signals and the trainable NN core.
// Drives one-cycle core strobes, waits on nn_done with a timeout, returns data/status.
module nn_la_sequencer
  import nn_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_toggle,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              ack_toggle,
  output logic              busy,
  output logic [1:0]        err,
  output logic [7:0]        op_count,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] nn_addr,
  output logic [DATA_W-1:0] nn_wdata,
  output logic              nn_we,
  output logic              nn_re,
  input  logic [DATA_W-1:0] nn_rdata,
  output logic              nn_fwd_start,
  output logic              nn_bwd_start,
  input  logic              nn_done,
  output seq_state_e        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Toggle handshake: firmware flips cmd_toggle with op/addr/data already stable
  // and holds them; a command is pending while the synchronized level differs from
  // ack_toggle in IDLE. ack_toggle copies the captured level when the command ends.
  logic tog_s;

  nn_toggle_sync u_tog_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (cmd_toggle),
    .q   (tog_s)
  );

  seq_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              tog_q;
  logic [CNT_W-1:0]  cnt_q;

  logic pending;
  logic in_wait;
  logic cnt_hit;
  logic timeout_evt;

  assign pending     = (state_q == S_IDLE) && (tog_s != ack_toggle);
  assign in_wait     = (state_q == S_FWD_WAIT) || (state_q == S_BWD_WAIT);
  assign cnt_hit     = (cnt_q == CNT_LAST);
  // A done pulse coinciding with the limit wins over the timeout.
  assign timeout_evt = in_wait && !nn_done && cnt_hit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pending) begin
          case (cmd_op)
            OP_WRITE:             state_d = S_WR;
            OP_READ:              state_d = S_RD;
            OP_FORWARD, OP_TRAIN: state_d = S_FWD;
            default:              state_d = S_FIN;
          endcase
        end
      end
      S_WR:       state_d = S_FIN;
      S_RD:       state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_FIN;
      S_FWD:      state_d = S_FWD_WAIT;
      S_FWD_WAIT: begin
        if (nn_done)      state_d = (op_q == OP_TRAIN) ? S_BWD : S_FIN;
        else if (cnt_hit) state_d = S_FIN;
      end
      S_BWD:      state_d = S_BWD_WAIT;
      S_BWD_WAIT: begin
        if (nn_done || cnt_hit) state_d = S_FIN;
      end
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_q       <= OP_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      tog_q      <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      ack_toggle <= 1'b0;
      err        <= ERR_NONE;
      op_count   <= 8'd0;
      rdata      <= '0;
    end else begin
      if (pending) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        tog_q  <= tog_s;
        busy   <= 1'b1;
      end

      if ((state_q == S_FWD) || (state_q == S_BWD)) cnt_q <= '0;
      else if (in_wait)                              cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == S_RD_CAP) rdata <= nn_rdata;

      if (timeout_evt) err[1] <= 1'b1;

      if (state_q == S_FIN) begin
        ack_toggle <= tog_q;
        op_count   <= op_count + 8'd1;
        busy       <= 1'b0;
        if (op_q == OP_CLR_ERR)     err    <= ERR_NONE;
        else if (!op_is_legal(op_q)) err[0] <= 1'b1;
      end
    end
  end

  // Strobes decode straight from state so they vanish the instant reset asserts.
  assign nn_we        = (state_q == S_WR);
  assign nn_re        = (state_q == S_RD);
  assign nn_fwd_start = (state_q == S_FWD);
  assign nn_bwd_start = (state_q == S_BWD);
  assign nn_addr      = addr_q;
  assign nn_wdata     = data_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_nn_la_sequencer.sv
// Bench for nn_la_sequencer: randomized LA commands against a command-level model
// of the sequencer plus a simple NN core model with programmable done delay.
module tb_nn_la_sequencer;
  import nn_seq_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;
  localparam int WAIT_LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_toggle;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              ack_toggle;
  logic              busy;
  logic [1:0]        err;
  logic [7:0]        op_count;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] nn_addr;
  logic [DATA_W-1:0] nn_wdata;
  logic              nn_we;
  logic              nn_re;
  logic [DATA_W-1:0] nn_rdata;
  logic              nn_fwd_start;
  logic              nn_bwd_start;
  logic              nn_done;
  seq_state_e        state_dbg;

  nn_la_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_toggle  (cmd_toggle),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .ack_toggle  (ack_toggle),
    .busy        (busy),
    .err         (err),
    .op_count    (op_count),
    .rdata       (rdata),
    .nn_addr     (nn_addr),
    .nn_wdata    (nn_wdata),
    .nn_we       (nn_we),
    .nn_re       (nn_re),
    .nn_rdata    (nn_rdata),
    .nn_fwd_start(nn_fwd_start),
    .nn_bwd_start(nn_bwd_start),
    .nn_done     (nn_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- core model ----------------
  logic [DATA_W-1:0] core_mem [256];
  int done_cnt;
  bit done_en    = 1'b1;
  int done_delay = 10;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) core_mem[i] <= '0;
      done_cnt <= 0;
      nn_done  <= 1'b0;
      nn_rdata <= '0;
    end else begin
      if (nn_we) core_mem[nn_addr] <= nn_wdata;
      if (nn_re) nn_rdata <= core_mem[nn_addr];
      nn_done <= done_en && (done_cnt == 1);
      if (nn_fwd_start || nn_bwd_start) done_cnt <= done_delay;
      else if (done_cnt > 0)            done_cnt <= done_cnt - 1;
    end
  end

  // ---------------- strobe monitor ----------------
  int we_n, re_n, fwd_n, bwd_n, clash_n;
  bit done_seen, bwd_early, busy_seen;
  logic [ADDR_W-1:0] last_we_addr;
  logic [DATA_W-1:0] last_we_data;

  always @(negedge clk) begin
    if (nn_we) begin
      we_n++;
      last_we_addr = nn_addr;
      last_we_data = nn_wdata;
    end
    if (nn_re) re_n++;
    if (nn_fwd_start) fwd_n++;
    if (nn_bwd_start) begin
      bwd_n++;
      if (!done_seen) bwd_early = 1'b1;
    end
    if (int'(nn_we) + int'(nn_re) + int'(nn_fwd_start) + int'(nn_bwd_start) > 1) clash_n++;
    if (nn_done) done_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0] model_mem [256];
  logic [DATA_W-1:0] exp_q [$];
  logic [7:0]        exp_count;
  logic [1:0]        exp_err;
  logic [DATA_W-1:0] exp_rdata;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    exp_q.delete();
    exp_count = 8'd0;
    exp_err   = 2'd0;
    exp_rdata = '0;
  endtask

  // ---------------- driver ----------------
  // Posts one command, waits for ack and checks it against the model.
  // Entered and left at posedge+1.
  task automatic do_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int delay, input bit done_on);
    int ew, er, ef, eb, exp_lat, lat;
    bit fwd_timeout;
    ew = 0; er = 0; ef = 0; eb = 0;
    fwd_timeout = !done_on || (delay >= TIMEOUT);
    exp_lat = 4;
    case (op)
      OP_WRITE: begin ew = 1; model_mem[addr] = data; exp_lat = 5; end
      OP_READ:  begin er = 1; exp_q.push_back(model_mem[addr]); exp_lat = 6; end
      OP_FORWARD: begin
        ef = 1;
        if (fwd_timeout) begin exp_err[1] = 1'b1; exp_lat = 5 + TIMEOUT; end
        else exp_lat = 6 + delay;
      end
      OP_TRAIN: begin
        ef = 1;
        if (fwd_timeout) begin exp_err[1] = 1'b1; exp_lat = 5 + TIMEOUT; end
        else begin eb = 1; exp_lat = 8 + 2 * delay; end
      end
      OP_CLR_ERR: exp_err = 2'd0;
      OP_NOP:     ;
      default:    exp_err[0] = 1'b1;
    endcase
    exp_count = exp_count + 8'd1;

    we_n = 0; re_n = 0; fwd_n = 0; bwd_n = 0;
    done_seen = 1'b0; bwd_early = 1'b0; busy_seen = 1'b0;
    done_delay = delay;
    done_en    = done_on;
    cmd_op     = op;
    cmd_addr   = addr;
    cmd_data   = data;
    cmd_toggle = ~cmd_toggle;
    lat = 0;
    while ((ack_toggle !== cmd_toggle) && (lat < WAIT_LIMIT)) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("ack_toggle", ack_toggle, cmd_toggle);
    check_eq("latency", lat, exp_lat);
    check_eq("busy_after_ack", busy, 1'b0);
    check_eq("busy_seen", busy_seen, 1'b1);
    check_eq("op_count", op_count, exp_count);
    check_eq("err", err, exp_err);
    check_eq("we_pulses", we_n, ew);
    check_eq("re_pulses", re_n, er);
    check_eq("fwd_pulses", fwd_n, ef);
    check_eq("bwd_pulses", bwd_n, eb);
    if (op == OP_WRITE) begin
      check_eq("we_addr", last_we_addr, addr);
      check_eq("we_data", last_we_data, data);
    end
    if (op == OP_READ) exp_rdata = exp_q.pop_front();
    if (op == OP_TRAIN) check_eq("bwd_after_done", bwd_early, 1'b0);
    check_eq("rdata", rdata, exp_rdata);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] saved_count;
  int guard;

  initial begin
    cmd_toggle = 1'b0;
    cmd_op     = OP_NOP;
    cmd_addr   = '0;
    cmd_data   = '0;
    clash_n    = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", {ack_toggle, busy, err, nn_we, nn_re, nn_fwd_start, nn_bwd_start}, 8'd0);
    check_eq("reset_count", op_count, 8'd0);
    check_eq("reset_rdata", rdata, 16'd0);
    check_eq("reset_nn_bus", {nn_addr, nn_wdata}, 24'd0);
    check_eq("reset_state", state_dbg, S_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed walk through each command class
    do_cmd(OP_WRITE, 8'h12, 16'hBEEF, 1, 1'b1);
    do_cmd(OP_READ, 8'h12, 16'h0000, 1, 1'b1);
    do_cmd(OP_TRAIN, 8'h00, 16'h0000, 10, 1'b1);
    do_cmd(OP_FORWARD, 8'h00, 16'h0000, 10, 1'b0);
    do_cmd(OP_CLR_ERR, 8'h00, 16'h0000, 1, 1'b1);
    do_cmd(OP_FORWARD, 8'h00, 16'h0000, TIMEOUT - 1, 1'b1);
    do_cmd(OP_FORWARD, 8'h00, 16'h0000, TIMEOUT, 1'b1);
    do_cmd(3'd7, 8'h33, 16'h1234, 1, 1'b1);
    do_cmd(OP_CLR_ERR, 8'h00, 16'h0000, 1, 1'b1);

    // Randomized mix; small address range so reads hit written locations
    for (int i = 0; i < 60; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 16'($urandom),
             $urandom_range(1, 12), 1'b1);
    end

    saved_count = op_count;
    for (int i = 0; i < 256; i++) do_cmd(OP_NOP, 8'h00, 16'h0000, 1, 1'b1);
    check_eq("nop_wrap", op_count, saved_count);

    // Reset while waiting on a forward pass that never completes
    done_en    = 1'b0;
    cmd_op     = OP_FORWARD;
    cmd_toggle = ~cmd_toggle;
    guard = 0;
    while ((state_dbg != S_FWD_WAIT) && (guard < WAIT_LIMIT)) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("reached_fwd_wait", state_dbg, S_FWD_WAIT);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midop_ctrl", {ack_toggle, busy, err, nn_we, nn_re, nn_fwd_start, nn_bwd_start}, 8'd0);
    check_eq("midop_count", op_count, 8'd0);
    check_eq("midop_rdata", rdata, 16'd0);
    check_eq("midop_nn_bus", {nn_addr, nn_wdata}, 24'd0);
    check_eq("midop_state", state_dbg, S_IDLE);
    cmd_toggle = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_cmd(OP_WRITE, 8'h05, 16'hA55A, 1, 1'b1);
    do_cmd(OP_READ, 8'h05, 16'h0000, 1, 1'b1);
    do_cmd(OP_TRAIN, 8'h00, 16'h0000, 3, 1'b1);

    check_eq("strobe_exclusive", clash_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_la_sequencer.md
Name: nn_la_sequencer

Overview:
Command sequencer between the logic-analyzer (LA) bank driven by management firmware and the trainable neural-network core. Firmware posts one command at a time with a toggle handshake: write/read a core register, run a forward pass, or run a full train step (forward then backward). The sequencer drives the core's control strobes, waits for completion with a timeout and returns read data and status on LA outputs. The status bits also feed the checkbits on mprj_io[31:16].

Parameters:
ADDR_W, 8, core register/weight address width
DATA_W, 16, core data width
TIMEOUT, 1024, max cycles to wait for nn_done; counter width is clog2(TIMEOUT+1)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_toggle  in  1  LA command strobe; each change of level posts one command
cmd_op  in  3  opcode: 0 NOP, 1 WRITE, 2 READ, 3 FORWARD, 4 TRAIN, 5 CLR_ERR, 6-7 illegal
cmd_addr  in  ADDR_W  operand address
cmd_data  in  DATA_W  operand write data
ack_toggle  out  1  equals the captured cmd_toggle once the command completes
busy  out  1  high from command capture until ack
err  out  2  sticky: 0 none, 1 illegal op, 2 timeout, 3 both/other
op_count  out  8  completed-command counter, wraps 255->0
rdata  out  DATA_W  last READ result
nn_addr  out  ADDR_W  core address
nn_wdata  out  DATA_W  core write data
nn_we  out  1  one-cycle write strobe
nn_re  out  1  one-cycle read strobe; data valid on nn_rdata the following cycle
nn_rdata  in  DATA_W  core read data
nn_fwd_start  out  1  one-cycle forward-pass start pulse
nn_bwd_start  out  1  one-cycle backward-pass start pulse
nn_done  in  1  one-cycle completion pulse from core (forward or backward)

Behaviour:
- Reset (async assert, sync deassert by the system): all outputs 0, FSM in IDLE, synchronizer flops 0, timeout counter 0.
- cmd_toggle passes through a 2-flop synchronizer to give tog_s. Pending = (tog_s != ack_toggle) while in IDLE.
- Firmware holds cmd_op/addr/data stable from before it flips the toggle until ack. On the pending cycle the sequencer captures op/addr/data/tog_s and busy goes high on the next edge.
- FSM states: IDLE, WR, RD, RD_CAP, FWD, FWD_WAIT, BWD, BWD_WAIT, FIN.
- IDLE: on pending, dispatch to WR (1), RD (2), FWD (3/4) or FIN (0, 5, illegal).
  - CLR_ERR clears err in FIN.
  - An illegal op sets err bit0 in FIN.
- WR: nn_we=1 for exactly one cycle with nn_addr/nn_wdata, then FIN.
- RD: nn_re=1 for one cycle, then RD_CAP latches nn_rdata into rdata, then FIN.
- FWD: nn_fwd_start pulse for one cycle, then FWD_WAIT.
  - FWD_WAIT on nn_done: op 3 goes to FIN, op 4 goes to BWD.
- BWD: nn_bwd_start pulse, then BWD_WAIT; on nn_done go to FIN.
- Timeout: the counter clears on entry to each WAIT state and increments each cycle in it. When it reaches TIMEOUT without nn_done: set err bit1 and go to FIN (no bwd phase). nn_done arriving in the same cycle as the limit counts as success.
- nn_done outside a WAIT state is ignored.
- FIN (1 cycle): ack_toggle <= captured toggle, op_count++ (wrap), busy <= 0, return to IDLE. A new command can be accepted on the cycle after FIN.
- Latency from tog_s change to ack change: WRITE 3 cycles, READ 4 cycles, NOP 2 cycles (plus the 2-cycle synchronizer).
- A toggle flip while busy is not accepted until FIN. A double flip during busy nets to no new command (level compare) and is documented as firmware error.
- Only one of nn_we/nn_re/nn_fwd_start/nn_bwd_start is high in any cycle.
- Reset mid-operation: all strobes drop immediately, no ack; the core is reset by the same signal.

Decomposition:
- Shared package nn_seq_pkg:
  - opcode constants OP_NOP..OP_CLR_ERR
  - err code constants
  - FSM state enum
- Sub-module nn_toggle_sync (2-flop synchronizer with async reset), reusable for other LA strobes.

Test Plan:
- Reset then WRITE addr 0x12 data 0xBEEF -> single nn_we cycle with nn_addr=0x12, nn_wdata=0xBEEF; ack_toggle follows; op_count=1; err=0.
- READ addr 0x12 with model returning 0xBEEF -> nn_re one cycle; rdata=0xBEEF at ack; busy low after.
- TRAIN with model asserting nn_done 10 cycles after each start -> fwd_start, then bwd_start only after the first done, then ack; op_count increments by exactly 1.
- FORWARD with nn_done never asserted, TIMEOUT=16 -> ack after 16 wait cycles; err=2; no bwd_start. CLR_ERR -> err=0.
- Opcode 7 -> no core strobes; err=1; ack returned; op_count increments. 256 NOPs wrap op_count to the same value.
- Assert wb_rst_i during FWD_WAIT -> all outputs 0 immediately; after release, a toggle flip is accepted normally.
